// File: rtl/pipeline_fetch_unit_if.sv
// Fetch-unit bundle: pipeline control in, instruction memory port, and the
// per-stage instruction/PC/valid pipe presented to the decoder and hazard logic.
interface pipeline_fetch_unit_if;
   localparam int unsigned XLEN = 16;
   localparam int unsigned OP_W = 5;

   logic            stall;
   logic            pc_enable;
   logic            br_taken;
   logic [XLEN-1:0] br_target;

   logic [XLEN-1:0] i_addr;
   logic            i_rd;
   logic [XLEN-1:0] i_rddata;

   logic [XLEN-1:0] inst_ipipe  [1:4];
   logic [XLEN-1:0] pc_ipipe    [1:4];
   logic            valid_ipipe [1:4];
   logic [OP_W-1:0] opcode      [1:4];

   // master: the fetch unit itself; slave: memory, decoder and hazard logic
   modport master (
      input  stall, pc_enable, br_taken, br_target, i_rddata,
      output i_addr, i_rd, inst_ipipe, pc_ipipe, valid_ipipe, opcode
   );

   modport slave (
      output stall, pc_enable, br_taken, br_target, i_rddata,
      input  i_addr, i_rd, inst_ipipe, pc_ipipe, valid_ipipe, opcode
   );
endinterface

// File: rtl/pipeline_fetch_unit.sv
// PC ownership, instruction-memory fetch and the 4-stage instruction pipe with
// stall bubbles, branch-shadow freeze and execute-stage redirect.
module pipeline_fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] NOP_INST = 16'h0007
) (
   input  logic                 clk,
   input  logic                 reset,
   pipeline_fetch_unit_if.master bus
);
   localparam int unsigned XLEN  = 16;
   localparam int unsigned OP_W  = 5;
   localparam int          FIRST = 2;
   localparam int          LAST  = 4;
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(2);

   typedef enum logic [1:0] {
      ACT_RUN,
      ACT_BRANCH,
      ACT_STALL,
      ACT_FREEZE
   } act_e;

   act_e            act;

   logic [XLEN-1:0] pc_q,         pc_d;
   logic [XLEN-1:0] f_pc_q,       f_pc_d;
   logic            f_valid_q,    f_valid_d;
   logic [XLEN-1:0] hold_inst_q,  hold_inst_d;
   logic            hold_valid_q, hold_valid_d;

   logic [XLEN-1:0] st_inst_q  [FIRST:LAST];
   logic [XLEN-1:0] st_inst_d  [FIRST:LAST];
   logic [XLEN-1:0] st_pc_q    [FIRST:LAST];
   logic [XLEN-1:0] st_pc_d    [FIRST:LAST];
   logic            st_valid_q [FIRST:LAST];
   logic            st_valid_d [FIRST:LAST];

   logic [XLEN-1:0] br_pc;
   logic [XLEN-1:0] s1_inst;

   assign br_pc   = bus.br_target & ~XLEN'(1);
   assign s1_inst = !f_valid_q   ? NOP_INST :
                    hold_valid_q ? hold_inst_q : bus.i_rddata;

   assign bus.i_rd   = !reset & (bus.br_taken | (!bus.stall & bus.pc_enable));
   assign bus.i_addr = bus.br_taken ? br_pc : pc_q;

   assign bus.inst_ipipe[1]  = s1_inst;
   assign bus.pc_ipipe[1]    = f_pc_q;
   assign bus.valid_ipipe[1] = f_valid_q;
   assign bus.opcode[1]      = s1_inst[OP_W-1:0];

   for (genvar g = FIRST; g <= LAST; g++) begin : g_stage
      assign bus.inst_ipipe[g]  = st_inst_q[g];
      assign bus.pc_ipipe[g]    = st_pc_q[g];
      assign bus.valid_ipipe[g] = st_valid_q[g];
      assign bus.opcode[g]      = st_inst_q[g][OP_W-1:0];
   end

   // Priority below reset: branch, then stall, then freeze, then normal fetch
   always_comb begin
      act = ACT_RUN;
      if (bus.br_taken)        act = ACT_BRANCH;
      else if (bus.stall)      act = ACT_STALL;
      else if (!bus.pc_enable) act = ACT_FREEZE;
   end

   always_comb begin
      pc_d         = pc_q;
      f_pc_d       = f_pc_q;
      f_valid_d    = f_valid_q;
      hold_inst_d  = hold_inst_q;
      hold_valid_d = hold_valid_q;
      st_inst_d    = st_inst_q;
      st_pc_d      = st_pc_q;
      st_valid_d   = st_valid_q;

      unique case (act)
         ACT_BRANCH: begin
            f_pc_d        = br_pc;
            f_valid_d     = 1'b1;
            pc_d          = br_pc + PC_STEP;
            hold_valid_d  = 1'b0;
            st_inst_d[2]  = NOP_INST;
            st_pc_d[2]    = '0;
            st_valid_d[2] = 1'b0;
            st_inst_d[3]  = NOP_INST;
            st_pc_d[3]    = '0;
            st_valid_d[3] = 1'b0;
            st_inst_d[4]  = st_inst_q[3];
            st_pc_d[4]    = st_pc_q[3];
            st_valid_d[4] = st_valid_q[3];
         end
         ACT_STALL: begin
            // First held cycle latches stage 1 so memory is not re-read
            if (!hold_valid_q) begin
               hold_inst_d  = s1_inst;
               hold_valid_d = f_valid_q;
            end
            st_inst_d[3]  = NOP_INST;
            st_pc_d[3]    = '0;
            st_valid_d[3] = 1'b0;
            st_inst_d[4]  = st_inst_q[3];
            st_pc_d[4]    = st_pc_q[3];
            st_valid_d[4] = st_valid_q[3];
         end
         ACT_FREEZE: begin
            if (!hold_valid_q) begin
               hold_inst_d  = s1_inst;
               hold_valid_d = f_valid_q;
            end
            st_inst_d[2]  = NOP_INST;
            st_pc_d[2]    = '0;
            st_valid_d[2] = 1'b0;
            st_inst_d[3]  = st_inst_q[2];
            st_pc_d[3]    = st_pc_q[2];
            st_valid_d[3] = st_valid_q[2];
            st_inst_d[4]  = st_inst_q[3];
            st_pc_d[4]    = st_pc_q[3];
            st_valid_d[4] = st_valid_q[3];
         end
         default: begin
            f_pc_d        = pc_q;
            f_valid_d     = 1'b1;
            pc_d          = pc_q + PC_STEP;
            hold_valid_d  = 1'b0;
            st_inst_d[2]  = s1_inst;
            st_pc_d[2]    = f_pc_q;
            st_valid_d[2] = f_valid_q;
            st_inst_d[3]  = st_inst_q[2];
            st_pc_d[3]    = st_pc_q[2];
            st_valid_d[3] = st_valid_q[2];
            st_inst_d[4]  = st_inst_q[3];
            st_pc_d[4]    = st_pc_q[3];
            st_valid_d[4] = st_valid_q[3];
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q         <= RESET_PC;
         f_pc_q       <= '0;
         f_valid_q    <= 1'b0;
         hold_inst_q  <= NOP_INST;
         hold_valid_q <= 1'b0;
         st_inst_q    <= '{default: NOP_INST};
         st_pc_q      <= '{default: '0};
         st_valid_q   <= '{default: 1'b0};
      end else begin
         pc_q         <= pc_d;
         f_pc_q       <= f_pc_d;
         f_valid_q    <= f_valid_d;
         hold_inst_q  <= hold_inst_d;
         hold_valid_q <= hold_valid_d;
         st_inst_q    <= st_inst_d;
         st_pc_q      <= st_pc_d;
         st_valid_q   <= st_valid_d;
      end
   end
endmodule

// File: tb/tb_pipeline_fetch_unit.sv
// Bench for pipeline_fetch_unit: directed vector table, PC-wrap instance and a
// randomized run against a stream-level reference model.
module tb_pipeline_fetch_unit;
   localparam logic [15:0] RST_M = 16'h0000;
   localparam logic [15:0] RST_W = 16'hFFFC;
   localparam logic [15:0] NOP   = 16'h0007;

   // control codes {reset, stall, pc_enable, br_taken}
   localparam logic [3:0] C_N  = 4'b0010;
   localparam logic [3:0] C_S  = 4'b0110;
   localparam logic [3:0] C_F  = 4'b0000;
   localparam logic [3:0] C_B  = 4'b0011;
   localparam logic [3:0] C_BS = 4'b0111;
   localparam logic [3:0] C_R  = 4'b1010;
   localparam logic [3:0] C_RS = 4'b1110;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        pc_enable;
   logic        br_taken;
   logic [15:0] br_target;
   logic [15:0] rd_m = '0;
   logic [15:0] rd_w = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipeline_fetch_unit_if bus_m ();
   pipeline_fetch_unit_if bus_w ();

   assign bus_m.stall     = stall;
   assign bus_m.pc_enable = pc_enable;
   assign bus_m.br_taken  = br_taken;
   assign bus_m.br_target = br_target;
   assign bus_m.i_rddata  = rd_m;
   assign bus_w.stall     = stall;
   assign bus_w.pc_enable = pc_enable;
   assign bus_w.br_taken  = br_taken;
   assign bus_w.br_target = br_target;
   assign bus_w.i_rddata  = rd_w;

   pipeline_fetch_unit #(.RESET_PC(RST_M), .NOP_INST(NOP)) u_dut (
      .clk(clk), .reset(reset), .bus(bus_m));
   pipeline_fetch_unit #(.RESET_PC(RST_W), .NOP_INST(NOP)) u_wrap (
      .clk(clk), .reset(reset), .bus(bus_w));

   // Distinct word per address (odd multiply is a bijection mod 2^16)
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      logic [15:0] p;
      p = a * 16'h9E37;
      return p ^ 16'hC3A5;
   endfunction

   always @(posedge clk) begin
      if (bus_m.i_rd) rd_m <= mem_word(bus_m.i_addr);
      if (bus_w.i_rd) rd_w <= mem_word(bus_w.i_addr);
   end

   // Reference: the instruction stream as a 4-slot pipe plus a next-fetch PC
   logic        ms_v  [1:4];
   logic [15:0] ms_pc [1:4];
   logic [15:0] m_next;

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 1; i <= 4; i++) begin
            ms_v[i]  <= 1'b0;
            ms_pc[i] <= 16'h0000;
         end
         m_next <= RST_M;
      end else if (br_taken) begin
         ms_v[4]  <= ms_v[3];  ms_pc[4] <= ms_pc[3];
         ms_v[3]  <= 1'b0;     ms_pc[3] <= 16'h0000;
         ms_v[2]  <= 1'b0;     ms_pc[2] <= 16'h0000;
         ms_v[1]  <= 1'b1;     ms_pc[1] <= br_target & 16'hFFFE;
         m_next   <= (br_target & 16'hFFFE) + 16'd2;
      end else if (stall) begin
         ms_v[4]  <= ms_v[3];  ms_pc[4] <= ms_pc[3];
         ms_v[3]  <= 1'b0;     ms_pc[3] <= 16'h0000;
      end else if (!pc_enable) begin
         ms_v[4]  <= ms_v[3];  ms_pc[4] <= ms_pc[3];
         ms_v[3]  <= ms_v[2];  ms_pc[3] <= ms_pc[2];
         ms_v[2]  <= 1'b0;     ms_pc[2] <= 16'h0000;
      end else begin
         ms_v[4]  <= ms_v[3];  ms_pc[4] <= ms_pc[3];
         ms_v[3]  <= ms_v[2];  ms_pc[3] <= ms_pc[2];
         ms_v[2]  <= ms_v[1];  ms_pc[2] <= ms_pc[1];
         ms_v[1]  <= 1'b1;     ms_pc[1] <= m_next;
         m_next   <= m_next + 16'd2;
      end
   end

   typedef struct packed {
      logic [3:0]  ctl;
      logic [15:0] tgt;
      logic        e_rd;
      logic [15:0] e_addr;
      logic [3:0]  e_v;
      logic [15:0] p1, p2, p3, p4;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [3:0] ctl, input logic [15:0] tgt,
                               input logic e_rd, input logic [15:0] e_addr,
                               input logic [3:0] e_v, input logic [15:0] p1,
                               input logic [15:0] p2, input logic [15:0] p3,
                               input logic [15:0] p4);
      vec_t v;
      v.ctl = ctl; v.tgt = tgt; v.e_rd = e_rd; v.e_addr = e_addr; v.e_v = e_v;
      v.p1 = p1; v.p2 = p2; v.p3 = p3; v.p4 = p4;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", nm, got, exp);
      end
   endtask

   task automatic drive(input logic [3:0] ctl, input logic [15:0] tgt);
      reset     = ctl[3];
      stall     = ctl[2];
      pc_enable = ctl[1];
      br_taken  = ctl[0];
      br_target = tgt;
   endtask

   task automatic check_stage(input string tag, input int i, input logic ev,
                              input logic [15:0] epc);
      logic [15:0] ei;
      ei = ev ? mem_word(epc) : NOP;
      chk($sformatf("%s s%0d valid", tag, i), 16'(bus_m.valid_ipipe[i]), 16'(ev));
      chk($sformatf("%s s%0d pc", tag, i), bus_m.pc_ipipe[i], epc);
      chk($sformatf("%s s%0d inst", tag, i), bus_m.inst_ipipe[i], ei);
      chk($sformatf("%s s%0d opcode", tag, i), 16'(bus_m.opcode[i]), 16'(ei[4:0]));
   endtask

   task automatic add_run();
      tbl.push_back(mk(C_N, 16'h0, 1'b1, 16'h0000, 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0));
      tbl.push_back(mk(C_N, 16'h0, 1'b1, 16'h0002, 4'b0001, 16'h0, 16'h0, 16'h0, 16'h0));
      tbl.push_back(mk(C_N, 16'h0, 1'b1, 16'h0004, 4'b0011, 16'h2, 16'h0, 16'h0, 16'h0));
      tbl.push_back(mk(C_S, 16'h0, 1'b0, 16'h0006, 4'b0111, 16'h4, 16'h2, 16'h0, 16'h0));
      tbl.push_back(mk(C_S, 16'h0, 1'b0, 16'h0006, 4'b1011, 16'h4, 16'h2, 16'h0, 16'h0));
      tbl.push_back(mk(C_N, 16'h0, 1'b1, 16'h0006, 4'b0011, 16'h4, 16'h2, 16'h0, 16'h0));
      tbl.push_back(mk(C_N, 16'h0, 1'b1, 16'h0008, 4'b0111, 16'h6, 16'h4, 16'h2, 16'h0));
      tbl.push_back(mk(C_F, 16'h0, 1'b0, 16'h000A, 4'b1111, 16'h8, 16'h6, 16'h4, 16'h2));
   endtask

   initial begin
      drive(C_R, 16'h0);
      repeat (3) @(negedge clk);

      // straight-line, 2-cycle stall, freeze then branch taken to 0x40
      tbl.push_back(mk(C_R, 16'h0, 1'b0, 16'h0000, 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0));
      add_run();
      tbl.push_back(mk(C_B, 16'h0041, 1'b1, 16'h0040, 4'b1101, 16'h8, 16'h0, 16'h6, 16'h4));
      tbl.push_back(mk(C_N, 16'h0, 1'b1, 16'h0042, 4'b1001, 16'h40, 16'h0, 16'h0, 16'h6));
      // freeze not taken, branch+stall collision, reset during stall
      tbl.push_back(mk(C_R, 16'h0, 1'b0, 16'h0044, 4'b0011, 16'h42, 16'h40, 16'h0, 16'h0));
      add_run();
      tbl.push_back(mk(C_N, 16'h0, 1'b1, 16'h000A, 4'b1101, 16'h8, 16'h0, 16'h6, 16'h4));
      tbl.push_back(mk(C_BS, 16'h0080, 1'b1, 16'h0080, 4'b1011, 16'hA, 16'h8, 16'h0, 16'h6));
      tbl.push_back(mk(C_N, 16'h0, 1'b1, 16'h0082, 4'b0001, 16'h80, 16'h0, 16'h0, 16'h0));
      tbl.push_back(mk(C_S, 16'h0, 1'b0, 16'h0084, 4'b0011, 16'h82, 16'h80, 16'h0, 16'h0));
      tbl.push_back(mk(C_RS, 16'h0, 1'b0, 16'h0084, 4'b0011, 16'h82, 16'h80, 16'h0, 16'h0));
      tbl.push_back(mk(C_N, 16'h0, 1'b1, 16'h0000, 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0));
      tbl.push_back(mk(C_N, 16'h0, 1'b1, 16'h0002, 4'b0001, 16'h0, 16'h0, 16'h0, 16'h0));

      foreach (tbl[r]) begin
         string tag;
         @(negedge clk);
         drive(tbl[r].ctl, tbl[r].tgt);
         #1;
         tag = $sformatf("vec%0d", r);
         chk({tag, " i_rd"}, 16'(bus_m.i_rd), 16'(tbl[r].e_rd));
         chk({tag, " i_addr"}, bus_m.i_addr, tbl[r].e_addr);
         check_stage(tag, 1, tbl[r].e_v[0], tbl[r].p1);
         check_stage(tag, 2, tbl[r].e_v[1], tbl[r].p2);
         check_stage(tag, 3, tbl[r].e_v[2], tbl[r].p3);
         check_stage(tag, 4, tbl[r].e_v[3], tbl[r].p4);
      end

      for (int c = 0; c < 1500; c++) begin
         string tag;
         @(negedge clk);
         reset     = ($urandom_range(0, 63) == 0);
         stall     = ($urandom_range(0, 3) == 0);
         pc_enable = ($urandom_range(0, 4) != 0);
         br_taken  = ($urandom_range(0, 7) == 0);
         br_target = 16'($urandom);
         #1;
         tag = $sformatf("rnd%0d", c);
         chk({tag, " i_rd"}, 16'(bus_m.i_rd),
             16'(!reset & (br_taken | (!stall & pc_enable))));
         chk({tag, " i_addr"}, bus_m.i_addr,
             br_taken ? (br_target & 16'hFFFE) : m_next);
         for (int i = 1; i <= 4; i++) check_stage(tag, i, ms_v[i], ms_pc[i]);
      end

      // PC wrap from 0xFFFC on the second instance
      @(negedge clk);
      drive(C_R, 16'h0);
      for (int c = 0; c < 4; c++) begin
         logic [15:0] ea;
         @(negedge clk);
         drive(C_N, 16'h0);
         #1;
         ea = RST_W + 16'(2 * c);
         chk($sformatf("wrap%0d i_addr", c), bus_w.i_addr, ea);
         chk($sformatf("wrap%0d i_rd", c), 16'(bus_w.i_rd), 16'h0001);
         chk($sformatf("wrap%0d s1 valid", c), 16'(bus_w.valid_ipipe[1]),
             (c == 0) ? 16'h0000 : 16'h0001);
         if (c > 0) chk($sformatf("wrap%0d s1 pc", c), bus_w.pc_ipipe[1], ea - 16'd2);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
